sp_sync_ctrl: RTL and testbench
===============================

# sp_sync_ctrl

Byte-alignment and link-lock controller for the serial-to-parallel receive path. It runs in the byte clock domain and watches the raw 8-bit word produced by the deserializer. It steers word alignment with single-cycle bit-slip requests until the comma symbol (0xBC) is seen, then declares the link active after a run of consecutive commas. Once locked it forwards non-comma bytes as valid data and drops lock when commas stop arriving.

## Interface
- COMMA, 8'hBC, idle/alignment symbol.
- LOCK_COUNT, 4, consecutive commas required to lock (1..15).
- HUNT_WINDOW, 16, consecutive non-comma bytes in HUNT before a bit-slip (2..255).
- SLIP_WAIT, 2, cycles ignored after a bit-slip while the deserializer settles (1..15).
- MAX_GAP, 64, consecutive non-comma bytes in LOCKED that cause loss of lock (2..1023).
- clk_4f  input  1  byte clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- rx_byte  input  8  raw deserializer word; sampled every cycle.
- bitslip  output  1  one-cycle pulse requesting a 1-bit alignment shift.
- active  output  1  link locked.
- valid_out  output  1  data_out carries a payload byte this cycle.
- data_out  output  8  payload byte, 8'h00 when not valid.
- lock_lost  output  1  one-cycle pulse when LOCKED is exited by gap timeout.
- slip_count  output  3  bit-slips issued since reset, wraps 7->0.

## Operation
- Reset: state HUNT; all counters 0; bitslip=0, active=0, valid_out=0, data_out=8'h00, lock_lost=0, slip_count=0. Reset takes effect immediately, including mid-lock or mid-slip.
- HUNT
  - rx_byte==COMMA: go to CONFIRM with comma count=1.
  - Otherwise increment hunt_cnt. On the HUNT_WINDOW-th consecutive non-comma byte: assert bitslip, increment slip_count, clear hunt_cnt, go to SLIP_WAIT.
- SLIP_WAIT
  - rx_byte is ignored, including commas, for SLIP_WAIT cycles; then return to HUNT with hunt_cnt=0.
- CONFIRM
  - rx_byte==COMMA: increment count. When count reaches LOCK_COUNT, go to LOCKED.
  - Non-comma: go to HUNT with hunt_cnt=0. No bit-slip is issued.
- LOCKED (active=1)
  - Comma: valid_out=0, data_out=8'h00, gap_cnt cleared.
  - Non-comma: valid_out=1, data_out=rx_byte, gap_cnt incremented.
  - The MAX_GAP-th consecutive non-comma byte is not delivered. Instead: valid_out=0, data_out=8'h00, active=0, lock_lost=1 for one cycle, state goes to HUNT, all counters cleared.
- Outputs not covered above hold 0: bitslip and lock_lost are pulses; valid_out=0 outside LOCKED.
- Counter widths: hunt_cnt 8 bits, gap_cnt 10 bits, comma count 4 bits. None of them can overflow within the parameter ranges.

## Timing
- All outputs are registered. Latency from rx_byte sampled at edge n to data_out/valid_out is one cycle (visible after edge n+1).
- Lock: the edge that samples the LOCK_COUNT-th comma sets active=1. That comma itself gives valid_out=0, so the first possible valid byte is the one sampled on the next edge.
- Bit-slip: bitslip is high for exactly the one cycle after the HUNT_WINDOW-th non-comma sample. The next SLIP_WAIT samples are ignored, and the first HUNT sample is at edge +SLIP_WAIT+1.
- Gap timeout: active falls and lock_lost pulses on the same edge. The next sample is evaluated in HUNT.
- Back-to-back bit-slips are separated by at least SLIP_WAIT+HUNT_WINDOW cycles.

## Structure
- Shared package sp_pkg holds the COMMA constant (8'hBC) and the state enum (HUNT, SLIP_WAIT, CONFIRM, LOCKED, 2-bit encoding). The deserializer and the transmit-side idle generator use the same package.
- Single module with one FSM and three counters; no sub-module is required.

## Test plan
- Aligned stream: 4x 0xBC then 0x12, 0x34 -> active=1 after the 4th comma; valid_out=1 with data_out=0x12 then 0x34; no bitslip.
- Misaligned stream: 0x79 repeated (0xBC rotated), model rotates by 1 per bitslip -> bitslip pulses every 18 cycles until 0xBC appears; slip_count matches the number of rotations; lock after 4 commas.
- Broken confirm: 3x 0xBC, 0x55, 4x 0xBC -> no lock at the 3rd comma; returns to HUNT; active=1 only after the second run; no bitslip.
- Gap timeout: after lock, 64 non-comma bytes 0x01..0x40 -> 0x01..0x3F delivered valid; 0x40 not delivered; active=0 and lock_lost pulse on the same edge.
- Comma in payload: after lock, 0xAA, 0xBC, 0xBB -> valid 1,0,1 with data 0xAA, 0x00, 0xBB; gap_cnt resets at 0xBC.
- Reset mid-lock and mid-slip: drive reset low asynchronously -> all outputs 0 immediately; relock after release needs 4 fresh commas.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared definitions for the serial receive/transmit path: the comma
// (idle/alignment) symbol and the alignment controller state encoding.
package sp_pkg;

  // Idle and alignment symbol sent by the transmit side between frames.
  localparam logic [7:0] COMMA = 8'hBC;

  // Alignment controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    CONFIRM   = 2'd2,
    LOCKED    = 2'd3
  } state_e;

  // True when a raw deserializer word is the comma symbol.
  function automatic logic is_comma(input logic [7:0] word);
    return (word == COMMA);
  endfunction

endpackage : sp_pkg

// File: rtl/sp_sync_ctrl.sv
// Byte-alignment and link-lock controller. Hunts for the comma symbol by
// requesting single-bit slips from the deserializer, confirms a run of
// consecutive commas before declaring the link active, then forwards
// non-comma bytes as payload until commas stop arriving.
module sp_sync_ctrl
  import sp_pkg::state_e;
  import sp_pkg::is_comma;
#(
  parameter int unsigned LOCK_COUNT  = 4,   // consecutive commas to lock (1..15)
  parameter int unsigned HUNT_WINDOW = 16,  // non-commas in HUNT before a slip (2..255)
  parameter int unsigned SLIP_WAIT   = 2,   // samples ignored after a slip (1..15)
  parameter int unsigned MAX_GAP     = 64   // non-commas in LOCKED that drop lock (2..1023)
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  output logic       bitslip,
  output logic       active,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       lock_lost,
  output logic [2:0] slip_count
);

  // Terminal values of the counters; each counter holds the number of
  // qualifying samples seen so far, so the N-th sample finds it at N-1.
  localparam logic [7:0] HUNT_LAST = 8'(HUNT_WINDOW - 1);
  localparam logic [7:0] SLIP_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [9:0] GAP_LAST  = 10'(MAX_GAP - 1);

  state_e     state_reg, state_next;
  // hunt_cnt also times the settle period in SLIP_WAIT: it is always zero
  // on entry there and is cleared again on the way back to HUNT.
  logic [7:0] hunt_cnt_reg, hunt_cnt_next;
  logic [3:0] comma_cnt_reg, comma_cnt_next;
  logic [9:0] gap_cnt_reg, gap_cnt_next;
  logic [2:0] slip_count_reg, slip_count_next;

  logic       bitslip_reg, bitslip_next;
  logic       active_reg, active_next;
  logic       valid_reg, valid_next;
  logic [7:0] data_reg, data_next;
  logic       lock_lost_reg, lock_lost_next;

  logic       rx_comma;

  assign rx_comma = is_comma(rx_byte);

  // State, counters and all outputs are registered; reset clears everything at once.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_reg      <= sp_pkg::HUNT;
      hunt_cnt_reg   <= '0;
      comma_cnt_reg  <= '0;
      gap_cnt_reg    <= '0;
      slip_count_reg <= '0;
      bitslip_reg    <= 1'b0;
      active_reg     <= 1'b0;
      valid_reg      <= 1'b0;
      data_reg       <= 8'h00;
      lock_lost_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hunt_cnt_reg   <= hunt_cnt_next;
      comma_cnt_reg  <= comma_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      slip_count_reg <= slip_count_next;
      bitslip_reg    <= bitslip_next;
      active_reg     <= active_next;
      valid_reg      <= valid_next;
      data_reg       <= data_next;
      lock_lost_reg  <= lock_lost_next;
    end
  end

  // Next-state, counter and output decode for the current sample.
  always_comb begin
    state_next      = state_reg;
    hunt_cnt_next   = hunt_cnt_reg;
    comma_cnt_next  = comma_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    slip_count_next = slip_count_reg;
    bitslip_next    = 1'b0;
    active_next     = 1'b0;
    valid_next      = 1'b0;
    data_next       = 8'h00;
    lock_lost_next  = 1'b0;

    unique case (state_reg)
      sp_pkg::HUNT: begin
        if (rx_comma) begin
          hunt_cnt_next = '0;
          if (LOCK_COUNT == 1) begin
            // A single comma is already a complete run.
            state_next     = sp_pkg::LOCKED;
            active_next    = 1'b1;
            comma_cnt_next = '0;
            gap_cnt_next   = '0;
          end else begin
            state_next     = sp_pkg::CONFIRM;
            comma_cnt_next = 4'd1;
          end
        end else if (hunt_cnt_reg == HUNT_LAST) begin
          // Window exhausted without a comma: shift alignment by one bit.
          bitslip_next    = 1'b1;
          slip_count_next = slip_count_reg + 3'd1;
          hunt_cnt_next   = '0;
          state_next      = sp_pkg::SLIP_WAIT;
        end else begin
          hunt_cnt_next = hunt_cnt_reg + 8'd1;
        end
      end

      sp_pkg::SLIP_WAIT: begin
        // Words are unreliable while the deserializer shifts; ignore them.
        if (hunt_cnt_reg == SLIP_LAST) begin
          hunt_cnt_next = '0;
          state_next    = sp_pkg::HUNT;
        end else begin
          hunt_cnt_next = hunt_cnt_reg + 8'd1;
        end
      end

      sp_pkg::CONFIRM: begin
        if (rx_comma) begin
          if (comma_cnt_reg == LOCK_LAST) begin
            state_next     = sp_pkg::LOCKED;
            active_next    = 1'b1;
            comma_cnt_next = '0;
            gap_cnt_next   = '0;
          end else begin
            comma_cnt_next = comma_cnt_reg + 4'd1;
          end
        end else begin
          // Run broken: alignment is probably fine, so restart the hunt
          // without slipping.
          state_next     = sp_pkg::HUNT;
          comma_cnt_next = '0;
          hunt_cnt_next  = '0;
        end
      end

      sp_pkg::LOCKED: begin
        active_next = 1'b1;
        if (rx_comma) begin
          gap_cnt_next = '0;
        end else if (gap_cnt_reg == GAP_LAST) begin
          // Commas have stopped: the byte that hits the limit is dropped.
          active_next    = 1'b0;
          lock_lost_next = 1'b1;
          state_next     = sp_pkg::HUNT;
          gap_cnt_next   = '0;
          hunt_cnt_next  = '0;
          comma_cnt_next = '0;
        end else begin
          valid_next   = 1'b1;
          data_next    = rx_byte;
          gap_cnt_next = gap_cnt_reg + 10'd1;
        end
      end

      default: begin
        state_next = sp_pkg::HUNT;
      end
    endcase
  end

  assign bitslip    = bitslip_reg;
  assign active     = active_reg;
  assign valid_out  = valid_reg;
  assign data_out   = data_reg;
  assign lock_lost  = lock_lost_reg;
  assign slip_count = slip_count_reg;

endmodule : sp_sync_ctrl

// File: tb/tb_sp_sync_ctrl.sv
// Self-checking bench for sp_sync_ctrl. A behavioural link model (run
// lengths and an ignore timer) predicts every output; a rotating channel
// model reproduces a misaligned deserializer that shifts by one bit per slip.
module tb_sp_sync_ctrl;

  localparam int LOCK_COUNT  = 4;
  localparam int HUNT_WINDOW = 16;
  localparam int SLIP_WAIT   = 2;
  localparam int MAX_GAP     = 64;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       bitslip, active, valid_out, lock_lost;
  logic [7:0] data_out;
  logic [2:0] slip_count;

  int checks = 0;
  int errors = 0;

  // Behavioural link model.
  bit m_locked;
  int m_commas, m_run, m_gap, m_ignore, m_slips;
  logic       e_bitslip, e_active, e_valid, e_lost;
  logic [7:0] e_data;
  logic [2:0] e_slips;

  // Channel misalignment: received word is the sent word rotated left by rot.
  int rot = 0;

  sp_sync_ctrl #(
    .LOCK_COUNT (LOCK_COUNT),
    .HUNT_WINDOW(HUNT_WINDOW),
    .SLIP_WAIT  (SLIP_WAIT),
    .MAX_GAP    (MAX_GAP)
  ) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .bitslip   (bitslip),
    .active    (active),
    .valid_out (valid_out),
    .data_out  (data_out),
    .lock_lost (lock_lost),
    .slip_count(slip_count)
  );

  always #5 clk_4f = ~clk_4f;

  function automatic logic [14:0] obs();
    return {bitslip, active, valid_out, data_out, lock_lost, slip_count};
  endfunction

  function automatic logic [14:0] expv();
    return {e_bitslip, e_active, e_valid, e_data, e_lost, e_slips};
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
    logic [15:0] d;
    d = {w, w} << r;
    return d[15:8];
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_commas = 0; m_run = 0; m_gap = 0; m_ignore = 0; m_slips = 0;
    e_bitslip = 0; e_active = 0; e_valid = 0; e_data = 8'h00; e_lost = 0; e_slips = 0;
  endfunction

  // Predict the outputs produced by one sampled word.
  function automatic void model_step(input logic [7:0] rx);
    e_bitslip = 0; e_active = 0; e_valid = 0; e_data = 8'h00; e_lost = 0;
    if (m_ignore > 0) begin
      m_ignore--;
    end else if (m_locked) begin
      if (rx == IDLE) begin
        m_gap = 0;
        e_active = 1;
      end else begin
        m_gap++;
        if (m_gap == MAX_GAP) begin
          m_locked = 0; m_gap = 0; m_run = 0; m_commas = 0;
          e_lost = 1;
        end else begin
          e_active = 1; e_valid = 1; e_data = rx;
        end
      end
    end else if (rx == IDLE) begin
      m_run = 0;
      m_commas++;
      if (m_commas == LOCK_COUNT) begin
        m_locked = 1; m_commas = 0; m_gap = 0;
        e_active = 1;
      end
    end else if (m_commas > 0) begin
      m_commas = 0;
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == HUNT_WINDOW) begin
        m_run = 0;
        m_slips++;
        m_ignore = SLIP_WAIT;
        e_bitslip = 1;
      end
    end
    e_slips = 3'(m_slips % 8);
  endfunction

  // Send one word through the channel, clock it in, advance the model.
  task automatic tick(input logic [7:0] tx);
    rx_byte = rotl(tx, rot);
    @(posedge clk_4f);
    #1;
    model_step(rx_byte);
    if (e_bitslip) rot = (rot + 7) % 8;
    if (bitslip || valid_out || lock_lost)
      $display("t=%0t rx=%02h bitslip=%0b active=%0b valid=%0b data=%02h lock_lost=%0b slips=%0d",
               $time, rx_byte, bitslip, active, valid_out, data_out, lock_lost, slip_count);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    rot = 0;
    @(posedge clk_4f);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", obs(), 15'd0);
    end
    apply_reset();
    tick(8'h00);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_first_cycle got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_aligned();
    apply_reset();
    for (int i = 0; i < LOCK_COUNT; i++) begin
      tick(IDLE);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL aligned_comma%0d got=%h want=%h", i, obs(), expv());
      end
    end
    checks++;
    if (active !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL aligned_lock active=%0b valid=%0b want active=1 valid=0", active, valid_out);
    end
    tick(8'h12);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h12 || bitslip !== 1'b0) begin
      errors++;
      $display("FAIL aligned_data0 valid=%0b data=%02h bitslip=%0b want 1 12 0", valid_out, data_out, bitslip);
    end
    tick(8'h34);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h34 || slip_count !== 3'd0) begin
      errors++;
      $display("FAIL aligned_data1 valid=%0b data=%02h slips=%0d want 1 34 0", valid_out, data_out, slip_count);
    end
  endtask

  task automatic test_misaligned();
    int rots [2];
    rots[0] = 1;
    rots[1] = $urandom_range(2, 7);
    for (int k = 0; k < 2; k++) begin
      int last_slip;
      int pulses;
      bit locked;
      apply_reset();
      rot = rots[k];
      last_slip = 0; pulses = 0; locked = 0;
      for (int c = 1; c <= 400 && !locked; c++) begin
        tick(IDLE);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL misalign_cycle%0d got=%h want=%h", c, obs(), expv());
        end
        if (bitslip === 1'b1) begin
          pulses++;
          checks++;
          if (c - last_slip != ((pulses == 1) ? HUNT_WINDOW : HUNT_WINDOW + SLIP_WAIT)) begin
            errors++;
            $display("FAIL misalign_spacing got=%0d want=%0d", c - last_slip,
                     (pulses == 1) ? HUNT_WINDOW : HUNT_WINDOW + SLIP_WAIT);
          end
          last_slip = c;
        end
        locked = e_active;
      end
      checks++;
      if (!locked || active !== 1'b1 || slip_count !== 3'(rots[k]) || pulses != rots[k]) begin
        errors++;
        $display("FAIL misalign_lock active=%0b slips=%0d pulses=%0d want active=1 slips=%0d",
                 active, slip_count, pulses, rots[k]);
      end
    end
    rot = 0;
  endtask

  task automatic test_broken_confirm();
    logic [7:0] seq [8] = '{IDLE, IDLE, IDLE, 8'h55, IDLE, IDLE, IDLE, IDLE};
    logic       want_active [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(seq[i]);
      checks++;
      if (obs() !== expv() || active !== want_active[i] || bitslip !== 1'b0) begin
        errors++;
        $display("FAIL broken_confirm%0d got=%h model=%h active want=%0b", i, obs(), expv(), want_active[i]);
      end
    end
  endtask

  task automatic lock_link();
    apply_reset();
    for (int i = 0; i < LOCK_COUNT; i++) tick(IDLE);
  endtask

  task automatic test_gap_timeout();
    lock_link();
    for (int i = 1; i <= MAX_GAP; i++) begin
      tick(8'(i));
      checks++;
      if (i < MAX_GAP) begin
        if (valid_out !== 1'b1 || data_out !== 8'(i) || active !== 1'b1 || lock_lost !== 1'b0) begin
          errors++;
          $display("FAIL gap_byte%0d valid=%0b data=%02h active=%0b lost=%0b want 1 %02h 1 0",
                   i, valid_out, data_out, active, lock_lost, 8'(i));
        end
      end else if (valid_out !== 1'b0 || data_out !== 8'h00 || active !== 1'b0 || lock_lost !== 1'b1) begin
        errors++;
        $display("FAIL gap_timeout valid=%0b data=%02h active=%0b lost=%0b want 0 00 0 1",
                 valid_out, data_out, active, lock_lost);
      end
    end
    tick(IDLE);
    checks++;
    if (lock_lost !== 1'b0 || active !== 1'b0 || obs() !== expv()) begin
      errors++;
      $display("FAIL gap_after lost=%0b active=%0b got=%h want=%h", lock_lost, active, obs(), expv());
    end
  endtask

  task automatic test_comma_payload();
    logic [7:0] seq [3]  = '{8'hAA, IDLE, 8'hBB};
    logic       wv  [3]  = '{1, 0, 1};
    logic [7:0] wd  [3]  = '{8'hAA, 8'h00, 8'hBB};
    lock_link();
    for (int i = 0; i < MAX_GAP - 2; i++) tick(8'h5A);
    for (int i = 0; i < 3; i++) begin
      tick(seq[i]);
      checks++;
      if (valid_out !== wv[i] || data_out !== wd[i] || active !== 1'b1) begin
        errors++;
        $display("FAIL comma_payload%0d valid=%0b data=%02h active=%0b want %0b %02h 1",
                 i, valid_out, data_out, active, wv[i], wd[i]);
      end
    end
    // The comma restarted the gap count: MAX_GAP-2 more bytes stay locked.
    for (int i = 0; i < MAX_GAP - 2; i++) tick(8'h77);
    checks++;
    if (active !== 1'b1 || valid_out !== 1'b1 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL comma_gap_reset active=%0b valid=%0b lost=%0b want 1 1 0", active, valid_out, lock_lost);
    end
  endtask

  task automatic test_reset_mid();
    lock_link();
    tick(8'h3C);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_lock got=%h want=%h", obs(), 15'd0);
    end
    model_reset();
    @(posedge clk_4f);
    #1;
    reset = 1'b1;
    for (int i = 0; i < LOCK_COUNT; i++) begin
      tick(IDLE);
      checks++;
      if (active !== ((i == LOCK_COUNT - 1) ? 1'b1 : 1'b0) || obs() !== expv()) begin
        errors++;
        $display("FAIL relock%0d got=%h want=%h", i, obs(), expv());
      end
    end
    apply_reset();
    rot = 3;
    for (int c = 0; c < 100 && !e_bitslip; c++) tick(IDLE);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_slip got=%h want=%h", obs(), 15'd0);
    end
    rot = 0;
    model_reset();
    @(posedge clk_4f);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    int n;
    apply_reset();
    rot = $urandom_range(0, 7);
    n = 0;
    while (n < 2500) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rot = $urandom_range(0, 7);
        len = 0;
      end else begin
        len = (kind < 5) ? $urandom_range(1, 8) : $urandom_range(1, 80);
      end
      for (int i = 0; i < len; i++) begin
        tick((kind < 5) ? IDLE : 8'($urandom));
        n++;
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL random_cycle%0d got=%h want=%h", n, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_aligned();
    test_misaligned();
    test_broken_confirm();
    test_gap_timeout();
    test_comma_payload();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sp_sync_ctrl
